// File: rtl/sar_adc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sar_adc_seq                                                    |
// | Purpose : Multi-channel successive-approximation ADC sequencer. Scans    |
// |           the enabled channels of an external analog mux. Each channel   |
// |           gets a settle delay, then a binary-search conversion against   |
// |           an external DAC and comparator. Scans run single-shot or       |
// |           continuously.                                                  |
// | Option  : `define SAR_ADC_AVG_EN makes each channel run 2**AVG_LOG2      |
// |           back-to-back conversions. The reported result is their         |
// |           truncated average. Without the macro, one conversion runs per  |
// |           channel and no accumulator is built.                           |
// | Ports   : clk, rst_n (async, active-low)                                 |
// |           start   - scan request, honoured in IDLE with ch_en != 0       |
// |           cont    - continuous mode, sampled at each end of scan         |
// |           ch_en   - channel enable mask, latched at scan start           |
// |           cmp     - comparator, 1 = analog input >= DACF                 |
// |           ch_sel  - mux select                                           |
// |           DACF    - DAC trial code (0 outside conversion)                |
// |           busy    - scan in progress                                     |
// |           den     - one-cycle result strobe                              |
// |           eoc     - one-cycle end-of-scan strobe (with last den)         |
// |           Dout    - result, held until the next den                      |
// |           Dch     - channel tag of Dout                                  |
// | Revision: 1.0 - initial multi-channel release                            |
// +--------------------------------------------------------------------------+
module sar_adc_seq #(
  parameter int ADC_WIDTH  = 8,
  parameter int CH_NUM     = 4,
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 2,
  localparam int CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cont,
  input  logic [CH_NUM-1:0]    ch_en,
  input  logic                 cmp,
  output logic [CHW-1:0]       ch_sel,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic                 busy,
  output logic                 den,
  output logic                 eoc,
  output logic [ADC_WIDTH-1:0] Dout,
  output logic [CHW-1:0]       Dch
);

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0]       SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [ADC_WIDTH-1:0] MSB_MASK    = ADC_WIDTH'(1) << (ADC_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CONV   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [CH_NUM-1:0]    en_q;
  logic [CHW-1:0]       ch_sel_q;
  logic [SCW-1:0]       settle_cnt;
  logic [ADC_WIDTH-1:0] result;      // bits decided so far
  logic [ADC_WIDTH-1:0] trial_mask;  // one-hot: bit under trial
  logic [ADC_WIDTH-1:0] dout_q;
  logic [CHW-1:0]       dch_q;

  logic [ADC_WIDTH-1:0] trial;
  logic [ADC_WIDTH-1:0] kept;
  logic                 last_bit;
  logic                 last_rep;
  logic [ADC_WIDTH-1:0] final_result;
  logic                 ch_en_any;
  logic [CHW-1:0]       lowest_ch;
  logic [CHW-1:0]       next_ch;
  logic                 has_next;

  // ---------------------------------------------------------------------
  // Successive-approximation datapath
  // ---------------------------------------------------------------------
  assign trial    = result | trial_mask;
  assign kept     = cmp ? trial : result;
  assign last_bit = trial_mask[0];

  // ---------------------------------------------------------------------
  // Channel selection helpers
  // ---------------------------------------------------------------------
  assign ch_en_any = |ch_en;

  always_comb begin
    lowest_ch = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        lowest_ch = CHW'(i);
      end
    end
  end

  // Next enabled channel strictly above the current one, from the latched mask.
  always_comb begin
    next_ch  = ch_sel_q;
    has_next = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (en_q[i] && (CHW'(i) > ch_sel_q)) begin
        next_ch  = CHW'(i);
        has_next = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional averaging
  // ---------------------------------------------------------------------
`ifdef SAR_ADC_AVG_EN
  localparam int ACCW = ADC_WIDTH + AVG_LOG2;
  localparam int RCW  = AVG_LOG2 + 1;
  localparam logic [RCW-1:0] REP_LAST = RCW'((1 << AVG_LOG2) - 1);

  logic [ACCW-1:0] acc;
  logic [RCW-1:0]  rep_cnt;   // conversions already accumulated
  logic [ACCW-1:0] acc_sum;

  // The final conversion is folded in on the fly, so acc only ever holds
  // the earlier conversions of the current channel.
  assign acc_sum      = acc + ACCW'(kept);
  assign last_rep     = (rep_cnt == REP_LAST);
  assign final_result = ADC_WIDTH'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      rep_cnt <= '0;
    end else if (state_q == SETTLE) begin
      acc     <= '0;
      rep_cnt <= '0;
    end else if ((state_q == CONV) && last_bit && !last_rep) begin
      acc     <= acc_sum;
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  // Without averaging the shift is always zero.
  localparam int AVG_SHIFT = 0 * AVG_LOG2;

  assign last_rep     = 1'b1;
  assign final_result = kept >> AVG_SHIFT;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    den     = 1'b0;
    eoc     = 1'b0;
    DACF    = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && ch_en_any) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_d = CONV;
        end
      end
      CONV: begin
        DACF = trial;
        if (last_bit && last_rep) begin
          state_d = DONE;
        end
      end
      DONE: begin
        den = 1'b1;
        eoc = !has_next;
        if (has_next) begin
          state_d = SETTLE;
        end else if (cont && ch_en_any) begin
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= '0;
      ch_sel_q   <= '0;
      settle_cnt <= '0;
      result     <= '0;
      trial_mask <= '0;
      dout_q     <= '0;
      dch_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && ch_en_any) begin
            en_q     <= ch_en;
            ch_sel_q <= lowest_ch;
          end
        end
        SETTLE: begin
          // Counter wraps to zero on exit, so every SETTLE entry starts at 0.
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            result     <= '0;
            trial_mask <= MSB_MASK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CONV: begin
          if (!last_bit) begin
            result     <= kept;
            trial_mask <= trial_mask >> 1;
          end else if (last_rep) begin
            // Result is published on entry to DONE so it is valid with den.
            result <= kept;
            dout_q <= final_result;
            dch_q  <= ch_sel_q;
          end else begin
            // Restart the binary search for the next averaged conversion.
            result     <= '0;
            trial_mask <= MSB_MASK;
          end
        end
        DONE: begin
          if (has_next) begin
            ch_sel_q <= next_ch;
          end else if (cont && ch_en_any) begin
            en_q     <= ch_en;
            ch_sel_q <= lowest_ch;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ch_sel = ch_sel_q;
  assign Dout   = dout_q;
  assign Dch    = dch_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sar_adc_seq                                                 |
// | Purpose : Self-checking bench for sar_adc_seq. A comparator model closes |
// |           the loop: cmp = (DACF <= sig[ch_sel]). Expected results come   |
// |           from scan rules: enabled channels in ascending order, each     |
// |           result equal to its input level, den at fixed offsets from the |
// |           start edge.                                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sar_adc_seq;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int S   = 2;
  localparam int A   = 2;
  localparam int CHW = 2;
  localparam int FIRST_DEN = S + W;      // cycles from start edge to first den
  localparam int SPACING   = 1 + S + W;  // den spacing between channels

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           cont = 1'b0;
  logic [N-1:0]   ch_en = '0;
  logic           cmp;
  logic [CHW-1:0] ch_sel;
  logic [W-1:0]   dacf;
  logic           busy;
  logic           den;
  logic           eoc;
  logic [W-1:0]   dout;
  logic [CHW-1:0] dch;

  logic [W-1:0]   sig [N];

  int checks = 0;
  int fails  = 0;

  // Observation records, indexed by cycle count after the start edge.
  int             ev_n   [$];
  logic [CHW-1:0] ev_ch  [$];
  logic [W-1:0]   ev_val [$];
  logic           ev_eoc [$];
  logic [W-1:0]   dac_trace [$];
  int             busy_fall;
  logic [N-1:0]   sel_seen;
  logic           busy_seen;

  always #5 clk = ~clk;

  assign cmp = (dacf <= sig[ch_sel]);

  sar_adc_seq #(
    .ADC_WIDTH (W),
    .CH_NUM    (N),
    .SETTLE_CYC(S),
    .AVG_LOG2  (A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .cont  (cont),
    .ch_en (ch_en),
    .cmp   (cmp),
    .ch_sel(ch_sel),
    .DACF  (dacf),
    .busy  (busy),
    .den   (den),
    .eoc   (eoc),
    .Dout  (dout),
    .Dch   (dch)
  );

  // Pulse start for one cycle; returns at the negedge just after the start edge.
  task automatic launch(input logic [N-1:0] mask, input logic c);
    @(negedge clk);
    ch_en = mask;
    cont  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record cycles 1..cycles after the current negedge.
  task automatic observe(input int cycles);
    ev_n.delete();
    ev_ch.delete();
    ev_val.delete();
    ev_eoc.delete();
    dac_trace.delete();
    busy_fall = -1;
    sel_seen  = '0;
    busy_seen = 1'b0;
    dac_trace.push_back(dacf);
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk);
      dac_trace.push_back(dacf);
      if (den) begin
        ev_n.push_back(n);
        ev_ch.push_back(dch);
        ev_val.push_back(dout);
        ev_eoc.push_back(eoc);
      end
      if (busy) begin
        sel_seen[ch_sel] = 1'b1;
        busy_seen = 1'b1;
      end else if (busy_fall < 0) begin
        busy_fall = n;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, den, eoc} !== 3'b000) begin
      fails++;
      $display("FAIL reset_strobes: busy/den/eoc=%b required 000", {busy, den, eoc});
    end
    checks++;
    if ({dacf, dout} !== '0) begin
      fails++;
      $display("FAIL reset_data: DACF=%h Dout=%h required 00 00", dacf, dout);
    end
    checks++;
    if ({ch_sel, dch} !== '0) begin
      fails++;
      $display("FAIL reset_sel: ch_sel=%0d Dch=%0d required 0 0", ch_sel, dch);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] code;
    logic [W-1:0] trial;
    logic [W-1:0] one;
    sig[0] = 8'h55;
    launch(4'b0001, 1'b0);
    observe(14);
    // Expected DAC trials: plain binary search against the input level.
    code = '0;
    one  = 8'd1;
    for (int b = W - 1; b >= 0; b--) begin
      trial = code | (one << b);
      checks++;
      if (dac_trace[S + (W - 1 - b)] !== trial) begin
        fails++;
        $display("FAIL single_dacf[%0d]: got %h required %h", W - 1 - b, dac_trace[S + (W - 1 - b)], trial);
      end
      if (trial <= sig[0]) code = trial;
    end
    checks++;
    if (dac_trace[S - 1] !== 8'h00 || dac_trace[FIRST_DEN] !== 8'h00) begin
      fails++;
      $display("FAIL single_dacf_idle: settle=%h done=%h required 00 00", dac_trace[S - 1], dac_trace[FIRST_DEN]);
    end
    checks++;
    if (ev_n.size() != 1) begin
      fails++;
      $display("FAIL single_den_count: got %0d required 1", ev_n.size());
    end else begin
      checks++;
      if (ev_n[0] != FIRST_DEN || ev_eoc[0] !== 1'b1) begin
        fails++;
        $display("FAIL single_den_time: cycle %0d eoc %b required cycle %0d eoc 1", ev_n[0], ev_eoc[0], FIRST_DEN);
      end
      checks++;
      if (ev_val[0] !== 8'h55 || ev_ch[0] !== 2'd0) begin
        fails++;
        $display("FAIL single_result: Dout=%h Dch=%0d required 55 0", ev_val[0], ev_ch[0]);
      end
    end
    checks++;
    if (busy_fall != FIRST_DEN + 1) begin
      fails++;
      $display("FAIL single_busy_fall: cycle %0d required %0d", busy_fall, FIRST_DEN + 1);
    end
    checks++;
    if (dout !== 8'h55) begin
      fails++;
      $display("FAIL single_dout_hold: got %h required 55", dout);
    end
  endtask

  task automatic test_sparse();
    sig[1] = 8'h00;
    sig[3] = 8'hFF;
    launch(4'b1010, 1'b0);
    observe(30);
    checks++;
    if (ev_n.size() != 2) begin
      fails++;
      $display("FAIL sparse_den_count: got %0d required 2", ev_n.size());
    end else begin
      checks++;
      if (ev_n[0] != FIRST_DEN || ev_ch[0] !== 2'd1 || ev_val[0] !== 8'h00 || ev_eoc[0] !== 1'b0) begin
        fails++;
        $display("FAIL sparse_first: cycle %0d Dch %0d Dout %h eoc %b required %0d 1 00 0",
                 ev_n[0], ev_ch[0], ev_val[0], ev_eoc[0], FIRST_DEN);
      end
      checks++;
      if (ev_n[1] - ev_n[0] != SPACING || ev_ch[1] !== 2'd3 || ev_val[1] !== 8'hFF || ev_eoc[1] !== 1'b1) begin
        fails++;
        $display("FAIL sparse_second: gap %0d Dch %0d Dout %h eoc %b required %0d 3 ff 1",
                 ev_n[1] - ev_n[0], ev_ch[1], ev_val[1], ev_eoc[1], SPACING);
      end
    end
    checks++;
    if ((sel_seen & 4'b0101) !== 4'b0000) begin
      fails++;
      $display("FAIL sparse_ch_sel: channels selected %b required none of 0101", sel_seen);
    end
  endtask

  task automatic test_random_scan();
    logic [N-1:0] mask;
    int           idx;
    int           last_n;
    for (int t = 0; t < 6; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < N; c++) sig[c] = W'($urandom);
      launch(mask, 1'b0);
      ch_en = N'($urandom);  // must not affect the scan in flight
      observe(SPACING * N + 4);
      idx    = 0;
      last_n = 0;
      for (int c = 0; c < N; c++) begin
        if (mask[c]) begin
          checks++;
          if (idx >= ev_n.size()) begin
            fails++;
            $display("FAIL rand_missing[%0d]: mask %b ch %0d got no den required one", t, mask, c);
          end else if (ev_ch[idx] !== CHW'(c) || ev_val[idx] !== sig[c] ||
                       ev_n[idx] != FIRST_DEN + SPACING * idx) begin
            fails++;
            $display("FAIL rand_result[%0d]: mask %b got ch %0d val %h cycle %0d required ch %0d val %h cycle %0d",
                     t, mask, ev_ch[idx], ev_val[idx], ev_n[idx], c, sig[c], FIRST_DEN + SPACING * idx);
          end else begin
            last_n = ev_n[idx];
          end
          idx++;
        end
      end
      checks++;
      if (ev_n.size() != idx || (idx > 0 && idx <= ev_n.size() && ev_eoc[idx - 1] !== 1'b1)) begin
        fails++;
        $display("FAIL rand_count_eoc[%0d]: mask %b got %0d dens required %0d with eoc on last", t, mask, ev_n.size(), idx);
      end
      checks++;
      if (busy_fall != last_n + 1) begin
        fails++;
        $display("FAIL rand_busy_fall[%0d]: cycle %0d required %0d", t, busy_fall, last_n + 1);
      end
    end
  endtask

  task automatic test_continuous();
    sig[0] = W'($urandom);
    launch(4'b0001, 1'b1);
    observe(40);
    checks++;
    if (ev_n.size() != 3) begin
      fails++;
      $display("FAIL cont_den_count: got %0d required 3", ev_n.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_n[i] != FIRST_DEN + SPACING * i || ev_eoc[i] !== 1'b1 || ev_val[i] !== sig[0]) begin
          fails++;
          $display("FAIL cont_den[%0d]: cycle %0d eoc %b Dout %h required %0d 1 %h",
                   i, ev_n[i], ev_eoc[i], ev_val[i], FIRST_DEN + SPACING * i, sig[0]);
        end
      end
    end
    // Cycle 40 lies inside the fourth scan's conversion.
    cont = 1'b0;
    observe(20);
    checks++;
    if (ev_n.size() != 1 || ev_n[0] != 3 || ev_eoc[0] !== 1'b1 || busy_fall != 4) begin
      fails++;
      $display("FAIL cont_drop: dens %0d busy_fall %0d required 1 den at 3 then busy_fall 4", ev_n.size(), busy_fall);
    end
    // Continuous with an empty re-latched mask stops after the scan.
    launch(4'b0001, 1'b1);
    ch_en = '0;
    observe(20);
    cont = 1'b0;
    checks++;
    if (ev_n.size() != 1 || busy_fall != FIRST_DEN + 1) begin
      fails++;
      $display("FAIL cont_empty_mask: dens %0d busy_fall %0d required 1 and %0d", ev_n.size(), busy_fall, FIRST_DEN + 1);
    end
  endtask

  task automatic test_ignored();
    int total;
    launch(4'b0000, 1'b0);
    observe(15);
    checks++;
    if (busy_seen !== 1'b0 || ev_n.size() != 0) begin
      fails++;
      $display("FAIL ignored_empty_mask: busy_seen %b dens %0d required 0 0", busy_seen, ev_n.size());
    end
    sig[0] = W'($urandom);
    sig[1] = ~sig[0];
    launch(4'b0001, 1'b0);
    observe(4);
    total = ev_n.size();
    start = 1'b1;
    ch_en = 4'b0010;
    observe(1);
    total += ev_n.size();
    start = 1'b0;
    observe(15);
    checks++;
    if (total != 0 || ev_n.size() != 1 || ev_n[0] != FIRST_DEN - 5 || ev_ch[0] !== 2'd0 ||
        ev_val[0] !== sig[0] || busy_fall != FIRST_DEN - 4) begin
      fails++;
      $display("FAIL ignored_mid_start: dens %0d/%0d busy_fall %0d required one den ch 0 val %h at %0d, busy_fall %0d",
               total, ev_n.size(), busy_fall, sig[0], FIRST_DEN - 5, FIRST_DEN - 4);
    end
  endtask

  task automatic test_reset_mid();
    sig[0] = W'($urandom);
    sig[1] = W'($urandom);
    launch(4'b0011, 1'b0);
    observe(5);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, den, eoc} !== 3'b000 || dacf !== '0 || ch_sel !== '0 || dout !== '0 || dch !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy %b den %b eoc %b DACF %h ch_sel %0d Dout %h Dch %0d required all 0",
               busy, den, eoc, dacf, ch_sel, dout, dch);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    launch(4'b0011, 1'b0);
    observe(30);
    checks++;
    if (ev_n.size() != 2 || ev_n[0] != FIRST_DEN || ev_val[0] !== sig[0] || ev_ch[0] !== 2'd0 ||
        ev_val[1] !== sig[1] || ev_ch[1] !== 2'd1 || ev_eoc[1] !== 1'b1) begin
      fails++;
      $display("FAIL reset_fresh: dens %0d required 2 results %h,%h on ch 0,1", ev_n.size(), sig[0], sig[1]);
    end
  endtask

`ifdef SAR_ADC_AVG_EN
  task automatic test_avg();
    int           den_n;
    logic [W-1:0] den_val;
    int           den_cnt;
    den_n   = -1;
    den_val = '0;
    den_cnt = 0;
    sig[0]  = 8'h55;
    launch(4'b0001, 1'b0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      // Each conversion occupies W cycles; switch level between conversions.
      if (n == S + W)     sig[0] = 8'h56;
      if (n == S + 2 * W) sig[0] = 8'h55;
      if (n == S + 3 * W) sig[0] = 8'h56;
      if (den) begin
        den_cnt++;
        den_n   = n;
        den_val = dout;
      end
    end
    checks++;
    if (den_cnt != 1 || den_n != S + W * (1 << A) || den_val !== 8'h55) begin
      fails++;
      $display("FAIL avg_result: dens %0d at %0d Dout %h required 1 at %0d Dout 55",
               den_cnt, den_n, den_val, S + W * (1 << A));
    end
  endtask
`endif

  initial begin
    for (int c = 0; c < N; c++) sig[c] = '0;
`ifdef SAR_ADC_AVG_EN
    test_reset();
    test_avg();
`else
    test_reset();
    test_single();
    test_sparse();
    test_random_scan();
    test_continuous();
    test_ignored();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sar_adc_seq.md
# sar_adc_seq

Multi-channel successor to the single-channel SAR ADC controller. It drives an external analog mux (`ch_sel`), a DAC (`DACF`) and a comparator (`cmp`), and scans a programmable set of channels in single-shot or continuous mode. Each enabled channel gets a settle delay followed by a binary-search conversion, with optional oversampling/averaging. Results stream out with a valid strobe and channel tag; a separate strobe marks end of scan.

## Interface
- `ADC_WIDTH`, 8: resolution; one bit decided per CONV cycle.
- `CH_NUM`, 4: number of mux channels (≥1).
- `SETTLE_CYC`, 2: mux settle cycles before each channel's first conversion (≥1).
- `AVG_LOG2`, 2: log2 of conversions averaged per channel; used only with `SAR_ADC_AVG_EN`.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: scan request; sampled in IDLE only.
- `cont  in  1`: continuous mode; sampled at each end of scan.
- `ch_en  in  CH_NUM`: channel enable mask; latched when a scan starts.
- `cmp  in  1`: comparator; 1 = input ≥ `DACF`.
- `ch_sel  out  $clog2(CH_NUM)` (min 1): mux select.
- `DACF  out  ADC_WIDTH`: DAC trial code.
- `busy  out  1`: scan in progress.
- `den  out  1`: one-cycle result valid.
- `eoc  out  1`: one-cycle end of scan, coincident with the last channel's `den`.
- `Dout  out  ADC_WIDTH`: result, held until the next `den`.
- `Dch  out  $clog2(CH_NUM)`: channel of `Dout`, held with it.

## Operation
- States: IDLE, SETTLE, CONV, DONE.
- IDLE → SETTLE when `start`=1 and `ch_en`≠0:
  - Latch mask to `en_q`.
  - `ch_sel` ← lowest set bit of the mask.
  - `start` is ignored when the mask is 0 or when not in IDLE.
- SETTLE: count `SETTLE_CYC` cycles; `DACF`=0; then → CONV. Clear result register and bit index k=0.
- CONV, cycle k (0..ADC_WIDTH-1):
  - `DACF` = decided bits | (1 << (ADC_WIDTH-1-k)).
  - At the closing edge, the trial bit is kept if `cmp`=1, cleared otherwise.
  - After bit 0: without averaging → DONE. With averaging, add result to accumulator (width ADC_WIDTH+AVG_LOG2). Repeat CONV (no re-settle) until 2^AVG_LOG2 conversions are done, then → DONE.
- DONE (one cycle):
  - `den`=1; `Dout` = result (averaged: accumulator >> AVG_LOG2, truncating); `Dch` = `ch_sel`.
  - If a higher enabled channel exists: `ch_sel` ← next enabled channel, → SETTLE.
  - Otherwise `eoc`=1. If `cont`=1: re-latch `ch_en`, select its lowest set bit, → SETTLE. If `cont`=1 but the new mask is 0, → IDLE.
  - Otherwise → IDLE.
- `busy`=1 in every state except IDLE.
- `DACF`=0 outside CONV.
- Dropping `cont` mid-scan: the current scan completes, then → IDLE.
- `ch_en` changes mid-scan have no effect until the next latch.
- Reset value of all outputs: 0. Reset mid-operation returns to IDLE immediately (asynchronously); the accumulator and partial results are discarded.

## Timing
- Let E0 be the edge sampling `start`. Per channel, without averaging:
  - SETTLE occupies the cycles after E0 … E0+SETTLE_CYC-1.
  - CONV occupies the next ADC_WIDTH cycles.
  - `den` is high in the cycle after edge E0+SETTLE_CYC+ADC_WIDTH.
- `den` spacing between consecutive channels: 1+SETTLE_CYC+ADC_WIDTH cycles.
- With averaging: each `den` is delayed by ADC_WIDTH·(2^AVG_LOG2−1) cycles relative to the non-averaged case.
- `cmp` is sampled on the edge ending each CONV cycle, so the comparator and DAC path must settle within one cycle.
- `busy` falls in the cycle after the final DONE; `start` is accepted from that cycle on.

## Configuration
- `SAR_ADC_AVG_EN` defined: accumulator and repeat counter are present; 2^AVG_LOG2 conversions per channel, averaged result.
- Not defined: one conversion per channel; `AVG_LOG2` is ignored; no accumulator logic is synthesized.

## Test plan
All scenarios use ADC_WIDTH=8, CH_NUM=4, SETTLE_CYC=2; the comparator model is `cmp` = (`DACF` ≤ sig[`ch_sel`]).
- Single channel: `ch_en`=0001, sig0=0x55, pulse `start` → `DACF` sequence 80,40,60,50,58,54,56,55; `den`+`eoc` in the cycle after edge E0+10; `Dout`=0x55, `Dch`=0; `busy` then falls.
- Sparse scan: `ch_en`=1010, sig1=0x00, sig3=0xFF → `den` with (`Dch`=1, `Dout`=0x00), then 11 cycles later (`Dch`=3, `Dout`=0xFF) with `eoc`; `ch_sel` is never 0 or 2.
- Continuous: `cont`=1, `ch_en`=0001 → `den`/`eoc` every 11 cycles. Drop `cont` mid-conversion → exactly one more `den`, then IDLE.
- Ignored requests: `start` with `ch_en`=0 → `busy` stays 0, no `den`. `start` pulsed during CONV → no effect on sequence or result.
- Reset: assert `rst_n`=0 mid-CONV → all outputs 0 immediately. Release, then `start` → correct fresh conversion.
- Averaging (`SAR_ADC_AVG_EN`, AVG_LOG2=2): sig0 alternates 0x55/0x56 per conversion → single `den` after 2+32 cycles, `Dout`=0x55 (sum 0x156 >> 2).
